// File: rtl/ps2_arrow_ctrl.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and held arrow-key state.
`timescale 1ns/1ps
module ps2_arrow_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned TO_W        = 16
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] code_data,
    output logic       code_ext,
    output logic       code_brk,
    output logic       frame_err,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0] SC_BAT   = 8'hAA;
    localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
    localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

    // Synchroniser stages; idle-high so reset never fakes a falling edge.
    logic clk_s1_q, clk_s2_q, clk_s2_prev_q;
    logic data_s1_q, data_s2_q;
    logic fall;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [BYTE_W-1:0]   sr_q, sr_d;
    logic                perr_q, perr_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                byte_ok;

    logic                code_valid_q, code_valid_d;
    logic [BYTE_W-1:0]   code_data_q, code_data_d;
    logic                code_ext_q, code_ext_d;
    logic                code_brk_q, code_brk_d;
    logic                frame_err_q, frame_err_d;
    logic                key_up_q, key_up_d;
    logic                key_down_q, key_down_d;
    logic                key_left_q, key_left_d;
    logic                key_right_q, key_right_d;

    // Two-flop synchronisers plus a delayed copy of the clock for edge detection.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_s2_prev_q <= 1'b1;
            data_s1_q     <= 1'b1;
            data_s2_q     <= 1'b1;
        end else begin
            clk_s1_q      <= ps2_clk;
            clk_s2_q      <= clk_s1_q;
            clk_s2_prev_q <= clk_s2_q;
            data_s1_q     <= ps2_data;
            data_s2_q     <= data_s1_q;
        end
    end

    assign fall = clk_s2_prev_q & ~clk_s2_q;

    // Deframer FSM, timeout, prefix tracking and key-state next values.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        sr_d         = sr_q;
        perr_d       = perr_q;
        to_cnt_d     = to_cnt_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        byte_ok      = 1'b0;
        code_valid_d = 1'b0;
        code_data_d  = code_data_q;
        code_ext_d   = code_ext_q;
        code_brk_d   = code_brk_q;
        frame_err_d  = 1'b0;
        key_up_d     = key_up_q;
        key_down_d   = key_down_q;
        key_left_d   = key_left_q;
        key_right_d  = key_right_q;

        if (state_q != IDLE) begin
            to_cnt_d = fall ? TO_W'(0) : to_cnt_q + TO_W'(1);
        end

        if ((state_q != IDLE) && (to_cnt_q == TO_LAST)) begin
            // Timeout wins over a coincident falling edge.
            state_d     = IDLE;
            to_cnt_d    = TO_W'(0);
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = CNT_W'(0);
                        to_cnt_d = TO_W'(0);
                    end
                end
                DATA: begin
                    sr_d[bitcnt_q] = data_s2_q;
                    if (bitcnt_q == CNT_W'(7)) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    perr_d  = ((^sr_q) ^ data_s2_q) != 1'b1;
                    state_d = STOP;
                end
                STOP: begin
                    state_d  = IDLE;
                    to_cnt_d = TO_W'(0);
                    if (data_s2_q && !perr_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (byte_ok) begin
            if (sr_q == SC_EXT) begin
                ext_d = 1'b1;
            end else if (sr_q == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                code_valid_d = 1'b1;
                code_data_d  = sr_q;
                code_ext_d   = ext_q;
                code_brk_d   = brk_q;
                ext_d        = 1'b0;
                brk_d        = 1'b0;
                if ((sr_q == SC_BAT) && !ext_q && !brk_q) begin
                    key_up_d    = 1'b0;
                    key_down_d  = 1'b0;
                    key_left_d  = 1'b0;
                    key_right_d = 1'b0;
                end
                if (ext_q) begin
                    // A make of one arrow releases its opposite; a break only clears itself.
                    if (sr_q == SC_UP) begin
                        key_up_d = !brk_q;
                        if (!brk_q) key_down_d = 1'b0;
                    end else if (sr_q == SC_DOWN) begin
                        key_down_d = !brk_q;
                        if (!brk_q) key_up_d = 1'b0;
                    end else if (sr_q == SC_LEFT) begin
                        key_left_d = !brk_q;
                        if (!brk_q) key_right_d = 1'b0;
                    end else if (sr_q == SC_RIGHT) begin
                        key_right_d = !brk_q;
                        if (!brk_q) key_left_d = 1'b0;
                    end
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            perr_q       <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            code_valid_q <= 1'b0;
            code_data_q  <= '0;
            code_ext_q   <= 1'b0;
            code_brk_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            key_up_q     <= 1'b0;
            key_down_q   <= 1'b0;
            key_left_q   <= 1'b0;
            key_right_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            sr_q         <= sr_d;
            perr_q       <= perr_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            code_valid_q <= code_valid_d;
            code_data_q  <= code_data_d;
            code_ext_q   <= code_ext_d;
            code_brk_q   <= code_brk_d;
            frame_err_q  <= frame_err_d;
            key_up_q     <= key_up_d;
            key_down_q   <= key_down_d;
            key_left_q   <= key_left_d;
            key_right_q  <= key_right_d;
        end
    end

    assign code_valid = code_valid_q;
    assign code_data  = code_data_q;
    assign code_ext   = code_ext_q;
    assign code_brk   = code_brk_q;
    assign frame_err  = frame_err_q;
    assign key_up     = key_up_q;
    assign key_down   = key_down_q;
    assign key_left   = key_left_q;
    assign key_right  = key_right_q;

endmodule

// File: tb/tb_ps2_arrow_ctrl.sv
// Directed bench for ps2_arrow_ctrl: decoding, prefixes, arrow state, errors, timeout, reset.
`timescale 1ns/1ps
module tb_ps2_arrow_ctrl;

    localparam int unsigned HALF_SLOW = 500;  // 40 us PS/2 period at 25 MHz
    localparam int unsigned HALF_FAST = 20;

    logic       clk;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       code_valid;
    logic [7:0] code_data;
    logic       code_ext;
    logic       code_brk;
    logic       frame_err;
    logic       key_up, key_down, key_left, key_right;

    ps2_arrow_ctrl dut (
        .vga_clk   (clk),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_valid(code_valid),
        .code_data (code_data),
        .code_ext  (code_ext),
        .code_brk  (code_brk),
        .frame_err (frame_err),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_err  = 0;
    int unsigned cyc    = 0;
    int unsigned cv_cnt = 0;
    int unsigned fe_cnt = 0;
    int unsigned fe_cyc = 0;
    int unsigned last_fall_cyc = 0;
    logic [7:0]  last_data = '0;
    logic        last_ext  = 1'b0;
    logic        last_brk  = 1'b0;
    logic [3:0]  snap_keys = '0;   // {up, down, left, right} in the code_valid cycle

    always @(posedge clk) cyc <= cyc + 1;

    // Capture one-cycle strobes away from the active edge.
    always @(negedge clk) begin
        if (code_valid) begin
            cv_cnt    = cv_cnt + 1;
            last_data = code_data;
            last_ext  = code_ext;
            last_brk  = code_brk;
            snap_keys = {key_up, key_down, key_left, key_right};
        end
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b, input int unsigned half);
        ps2_data = b;
        wait_cyc(half);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(half);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input int unsigned half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
        ps2_bit((~^b) ^ bad_par, half);
        ps2_bit(1'b1, half);
        wait_cyc(8);
    endtask

    task automatic send_fast(input logic [7:0] b);
        send_byte(b, 1'b0, HALF_FAST);
    endtask

    function automatic logic [15:0] out_vec();
        return {code_valid, code_data, code_ext, code_brk, frame_err,
                key_up, key_down, key_left, key_right};
    endfunction

    initial begin
        int unsigned exp_cv;
        int unsigned exp_fe;
        int unsigned waited;
        int unsigned delta;

        reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check_eq("reset_outputs", 32'(out_vec()), 32'h0);
        reset_n = 1'b1;
        wait_cyc(5);

        // Plain make code at the real PS/2 rate.
        send_byte(8'h1C, 1'b0, HALF_SLOW);
        exp_cv = 1; exp_fe = 0;
        check_eq("t1_cv_count", cv_cnt, exp_cv);
        check_eq("t1_data", 32'(last_data), 32'h1C);
        check_eq("t1_ext", 32'(last_ext), 32'h0);
        check_eq("t1_brk", 32'(last_brk), 32'h0);
        check_eq("t1_fe_count", fe_cnt, exp_fe);

        // Up arrow make then break.
        send_fast(8'hE0); send_fast(8'h75);
        exp_cv++;
        check_eq("t2_make_cv", cv_cnt, exp_cv);
        check_eq("t2_make_ext", 32'(last_ext), 32'h1);
        check_eq("t2_make_brk", 32'(last_brk), 32'h0);
        check_eq("t2_make_keys", 32'(snap_keys), 32'b1000);
        send_fast(8'hE0); send_fast(8'hF0); send_fast(8'h75);
        exp_cv++;
        check_eq("t2_brk_cv", cv_cnt, exp_cv);
        check_eq("t2_brk_ext", 32'(last_ext), 32'h1);
        check_eq("t2_brk_brk", 32'(last_brk), 32'h1);
        check_eq("t2_brk_keys", 32'(snap_keys), 32'b0000);

        // Down cancels held up.
        send_fast(8'hE0); send_fast(8'h75);
        send_fast(8'hE0); send_fast(8'h72);
        exp_cv += 2;
        check_eq("t3_cv", cv_cnt, exp_cv);
        check_eq("t3_keys", 32'(snap_keys), 32'b0100);

        // Bad parity drops the byte and the pending E0.
        send_fast(8'hE0);
        send_byte(8'h1C, 1'b1, HALF_FAST);
        exp_fe++;
        check_eq("t4_fe_count", fe_cnt, exp_fe);
        check_eq("t4_no_cv", cv_cnt, exp_cv);
        send_fast(8'h6B);
        exp_cv++;
        check_eq("t4_data", 32'(last_data), 32'h6B);
        check_eq("t4_ext_cleared", 32'(last_ext), 32'h0);
        check_eq("t4_keys", 32'(snap_keys), 32'b0100);

        // Abandoned frame: start + 4 data bits, then silence until timeout.
        ps2_bit(1'b0, HALF_FAST);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, HALF_FAST);
        waited = 0;
        while (fe_cnt == exp_fe && waited < 60000) begin
            wait_cyc(1);
            waited++;
        end
        exp_fe++;
        check_eq("t5_fe_count", fe_cnt, exp_fe);
        delta = fe_cyc - last_fall_cyc;
        check_eq("t5_timeout_window", 32'((delta >= 50000) && (delta <= 50006)), 32'h1);
        check_eq("t5_no_cv", cv_cnt, exp_cv);
        send_fast(8'h1C);
        exp_cv++;
        check_eq("t5_cv", cv_cnt, exp_cv);
        check_eq("t5_data", 32'(last_data), 32'h1C);
        check_eq("t5_ext", 32'(last_ext), 32'h0);

        // BAT clears held arrows.
        send_fast(8'hE0); send_fast(8'h6B);
        send_fast(8'hE0); send_fast(8'h75);
        check_eq("t6_held_keys", 32'({key_up, key_down, key_left, key_right}), 32'b1010);
        send_fast(8'hAA);
        exp_cv += 3;
        check_eq("t6_cv", cv_cnt, exp_cv);
        check_eq("t6_data", 32'(last_data), 32'hAA);
        check_eq("t6_bat_keys", 32'(snap_keys), 32'b0000);

        // Mid-frame reset with a key held and an E0 pending.
        send_fast(8'hE0); send_fast(8'h74);
        exp_cv++;
        check_eq("t6_right_held", 32'(snap_keys), 32'b0001);
        send_fast(8'hE0);
        ps2_bit(1'b0, HALF_FAST);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, HALF_FAST);
        reset_n = 1'b0;
        wait_cyc(3);
        check_eq("t6_reset_outputs", 32'(out_vec()), 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(5);
        check_eq("t6_reset_no_cv", cv_cnt, exp_cv);
        send_fast(8'h6B);
        exp_cv++;
        check_eq("t6_post_cv", cv_cnt, exp_cv);
        check_eq("t6_post_data", 32'(last_data), 32'h6B);
        check_eq("t6_post_ext", 32'(last_ext), 32'h0);
        check_eq("t6_post_keys", 32'(snap_keys), 32'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
